// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//
// Four-slot time-division demultiplexer. One shared data lane carries four
// channels in a repeating frame of slots 0..3. Slot 0 is marked by a sync
// strobe. The block tracks the slot position and steers each beat into that
// channel's staging register. Each completed frame is presented as four
// parallel channel outputs under a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   beat present on in_data this cycle
//   in_sync    marks the beat as slot 0 (ignored when in_valid=0)
//   in_data    slot sample, WIDTH bits
//   out_ready  consumer accepts the presented frame
//   out0..out3 channel 0..3 samples of the last delivered frame
//   out_valid  out0..out3 hold an unconsumed frame
//   locked     frame alignment acquired (LOCKED state)
//   slot       slot index expected for the next beat
//   sync_err   one-cycle pulse after a framing violation
//   overrun    sticky; a completed frame was dropped (cleared by reset only)
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err,
  output logic             overrun
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  // Slot 3 needs no staging register: it is taken straight from in_data
  // on the completing beat.
  logic [2:0][WIDTH-1:0]   stage_q, stage_d;
  logic [3:0][WIDTH-1:0]   frame_q, frame_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic                    overrun_q, overrun_d;

  logic                    frame_done;
  logic                    frame_load;

  // ---------------------------------------------------------------------------
  // Next-state logic: slot tracking, staging, frame delivery
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    stage_d     = stage_q;
    frame_d     = frame_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    sync_err_d  = 1'b0;
    frame_done  = 1'b0;
    frame_load  = 1'b0;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sync) begin
            stage_d[0] = in_data;
            state_d    = LOCKED;
            slot_d     = 2'd1;
          end
        end

        LOCKED: begin
          if (in_sync) begin
            // Sync at slot 0 is the normal frame start. Sync anywhere else
            // is an early sync: the partial frame is abandoned and this beat
            // restarts the frame.
            sync_err_d = (slot_q != 2'd0);
            stage_d[0] = in_data;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Missing sync: alignment is lost, hunt for the next strobe.
            sync_err_d = 1'b1;
            state_d    = HUNT;
            slot_d     = 2'd0;
          end else begin
            case (slot_q)
              2'd1:    stage_d[1] = in_data;
              2'd2:    stage_d[2] = in_data;
              default: frame_done = 1'b1;
            endcase
            slot_d = slot_q + 2'd1;
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end

    // A completed frame loads if the output register is free or is being
    // consumed on this same edge; otherwise it is dropped.
    frame_load = frame_done && (!out_valid_q || out_ready);

    if (frame_load) begin
      frame_d[0]  = stage_q[0];
      frame_d[1]  = stage_q[1];
      frame_d[2]  = stage_q[2];
      frame_d[3]  = in_data;
      out_valid_d = 1'b1;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (frame_done) begin
        overrun_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the staging and output data registers are reset along with the
  // control state, so every output is defined from reset onward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      stage_q     <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out0      = frame_q[0];
  assign out1      = frame_q[1];
  assign out2      = frame_q[2];
  assign out3      = frame_q[3];
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign slot      = slot_q;
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//
// Self-checking bench for tdm_demux4. Stimulus pushes each frame it expects
// to see delivered into a queue; a monitor pops and compares whenever the DUT
// hands a frame over (out_valid && out_ready). Control/status outputs are
// checked directly from the stimulus thread one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             out_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;
  logic             overrun;

  int checks;
  int errors;
  int sync_err_cnt;

  logic [31:0] exp_q[$];

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .locked    (locked),
    .slot      (slot),
    .sync_err  (sync_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One beat, applied on the next rising edge; returns 1 time unit after it.
  task automatic beat(input logic s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input bit deliver);
    if (deliver) exp_q.push_back({a, b, c, d});
    beat(1'b1, a);
    beat(1'b0, b);
    beat(1'b0, c);
    beat(1'b0, d);
  endtask

  // Monitor: compares every handed-over frame against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sync_err) sync_err_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("frame_queue_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          check("frame_data", {out0, out1, out2, out3}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base [3];
    checks       = 0;
    errors       = 0;
    sync_err_cnt = 0;
    base[0] = 8'hC0;
    base[1] = 8'hD0;
    base[2] = 8'hE0;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outs", {out0, out1, out2, out3}, 32'h0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, out_valid one cycle after the D4 beat
    out_ready = 1'b1;
    send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_outs", {out0, out1, out2, out3}, 32'hA1B2C3D4);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_slot", 32'(slot), 32'd0);
    idle(1);
    check("t1_out_valid_drop", 32'(out_valid), 32'd0);

    // Three frames with mid-frame gaps
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({base[f], base[f] + 8'd1, base[f] + 8'd2, base[f] + 8'd3});
      for (int b = 0; b < 4; b++) begin
        beat(b == 0, base[f] + 8'(b));
        if (b == f) begin
          idle(2);
          check("t2_gap_slot", 32'(slot), 32'((b + 1) % 4));
        end
      end
    end
    idle(2);
    check("t2_no_sync_err", 32'(sync_err_cnt), 32'd0);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: second frame dropped, overrun set
    out_ready = 1'b0;
    send_frame(8'h11, 8'h12, 8'h13, 8'h14, 1'b1);
    send_frame(8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_hold", {out0, out1, out2, out3}, 32'h11121314);
    check("t3_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("t3_valid_cleared", 32'(out_valid), 32'd0);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    out_ready = 1'b0;

    // Consume and reload on the same edge
    send_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b1);
    exp_q.push_back(32'h41424344);
    beat(1'b1, 8'h41);
    beat(1'b0, 8'h42);
    beat(1'b0, 8'h43);
    out_ready = 1'b1;
    beat(1'b0, 8'h44);
    out_ready = 1'b0;
    check("t4_valid_stays", 32'(out_valid), 32'd1);
    check("t4_outs_new", {out0, out1, out2, out3}, 32'h41424344);
    idle(1);
    out_ready = 1'b1;
    idle(1);
    check("t4_valid_cleared", 32'(out_valid), 32'd0);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Early sync on slot 2
    beat(1'b1, 8'h51);
    beat(1'b0, 8'h52);
    beat(1'b1, 8'h60);
    check("t5_sync_err", 32'(sync_err), 32'd1);
    check("t5_slot", 32'(slot), 32'd1);
    check("t5_locked", 32'(locked), 32'd1);
    exp_q.push_back(32'h60616263);
    beat(1'b0, 8'h61);
    check("t5_sync_err_pulse", 32'(sync_err), 32'd0);
    beat(1'b0, 8'h62);
    beat(1'b0, 8'h63);
    check("t5_valid", 32'(out_valid), 32'd1);
    idle(1);
    check("t5_err_count", 32'(sync_err_cnt), 32'd1);

    // Missing sync at slot 0
    beat(1'b0, 8'h70);
    check("t6_sync_err", 32'(sync_err), 32'd1);
    check("t6_unlocked", 32'(locked), 32'd0);
    beat(1'b0, 8'h71);
    beat(1'b0, 8'h72);
    check("t6_hunt_locked", 32'(locked), 32'd0);
    check("t6_hunt_slot", 32'(slot), 32'd0);
    send_frame(8'h80, 8'h81, 8'h82, 8'h83, 1'b1);
    check("t6_relock_valid", 32'(out_valid), 32'd1);
    idle(2);
    check("t6_err_count", 32'(sync_err_cnt), 32'd2);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a frame pending
    out_ready = 1'b0;
    send_frame(8'h90, 8'h91, 8'h92, 8'h93, 1'b1);
    beat(1'b1, 8'hA0);
    beat(1'b0, 8'hA1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t7_valid", 32'(out_valid), 32'd0);
    check("t7_outs", {out0, out1, out2, out3}, 32'h0);
    check("t7_locked", 32'(locked), 32'd0);
    check("t7_slot", 32'(slot), 32'd0);
    check("t7_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1);
    check("t7_fresh_outs", {out0, out1, out2, out3}, 32'hB0B1B2B3);
    check("t7_fresh_locked", 32'(locked), 32'd1);
    idle(3);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
